// File: rtl/input_debouncer_if.sv
// Bundle of the debouncer's per-channel pin, level, pulse and event signals.
// The slave side is the debouncer; the master side is whatever drives the raw
// pins and consumes the cleaned levels.
interface input_debouncer_if #(
  parameter int unsigned WIDTH = 2
);

  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] db_out;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  logic [WIDTH-1:0] evt_clear;
  logic [WIDTH-1:0] evt_flags;
  logic             irq;

  modport slave (
    input  raw_in,
    input  evt_clear,
    output db_out,
    output rise_pulse,
    output fall_pulse,
    output evt_flags,
    output irq
  );

  modport master (
    output raw_in,
    output evt_clear,
    input  db_out,
    input  rise_pulse,
    input  fall_pulse,
    input  evt_flags,
    input  irq
  );

endinterface

// File: rtl/input_debouncer.sv
// Per-channel synchronizer, debouncer and edge detector for board keys and
// switches. Each channel runs a 2-FF synchronizer, optional polarity
// inversion, and a stability counter that must see STABLE_CYCLES consecutive
// differing samples before the debounced level follows the input.
//
// Optional feature macro: DEBOUNCE_EVT_EN
//   defined   -> sticky press flags (evt_flags) with per-channel clear and a
//                registered irq = |evt_flags.
//   undefined -> evt_clear ignored, evt_flags and irq tied low, no flag flops.
module input_debouncer #(
  parameter int unsigned WIDTH         = 2,
  parameter int unsigned STABLE_CYCLES = 50000,
  parameter bit          INVERT        = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input_debouncer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

  // Final count value: the next differing sample after this one is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  // Raw pin level of a released key / switch, and the XOR mask that maps it
  // to a normalised 0.
  localparam logic [WIDTH-1:0] REL_LVL = {WIDTH{INVERT}};

  logic [WIDTH-1:0]             sync1_q;
  logic [WIDTH-1:0]             sync2_q;
  logic [WIDTH-1:0]             norm_c;

  logic [WIDTH-1:0]             db_q;
  logic [WIDTH-1:0]             db_d;
  logic [WIDTH-1:0]             rise_q;
  logic [WIDTH-1:0]             rise_d;
  logic [WIDTH-1:0]             fall_q;
  logic [WIDTH-1:0]             fall_d;
  logic [WIDTH-1:0][CNT_W-1:0]  cnt_q;
  logic [WIDTH-1:0][CNT_W-1:0]  cnt_d;

  // Two-stage synchronizer; resets to the released pin level so that leaving
  // reset never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= REL_LVL;
      sync2_q <= REL_LVL;
    end else begin
      sync1_q <= bus.raw_in;
      sync2_q <= sync1_q;
    end
  end

  // Normalise polarity so that 1 always means asserted / pressed.
  assign norm_c = sync2_q ^ REL_LVL;

  // Per-channel acceptance decision: count consecutive differing samples,
  // restart on any bounce back, flip the level on the final one.
  always_comb begin
    db_d   = db_q;
    cnt_d  = cnt_q;
    rise_d = '0;
    fall_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (norm_c[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= CNT_LAST) begin
        db_d[i]   = norm_c[i];
        cnt_d[i]  = '0;
        rise_d[i] = norm_c[i];
        fall_d[i] = ~norm_c[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Debounced level, counters and edge pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_q   <= '0;
      cnt_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      db_q   <= db_d;
      cnt_q  <= cnt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign bus.db_out     = db_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;

`ifdef DEBOUNCE_EVT_EN

  logic [WIDTH-1:0] flags_q;
  logic             irq_q;

  // Sticky press flags: a registered rise pulse sets, clear resets, set wins.
  // The interrupt follows the flags one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      flags_q <= (flags_q & ~bus.evt_clear) | rise_q;
      irq_q   <= |flags_q;
    end
  end

  assign bus.evt_flags = flags_q;
  assign bus.irq       = irq_q;

`else

  // Event logic absent: clear input has no effect.
  logic unused_evt_clear;
  assign unused_evt_clear = ^bus.evt_clear;

  assign bus.evt_flags = '0;
  assign bus.irq       = 1'b0;

`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer (WIDTH=2, STABLE_CYCLES=4, INVERT=1). A reference
// model decides acceptance from a sliding window of the last STABLE_CYCLES
// normalised samples; directed scenarios additionally check fixed timings.
module tb_input_debouncer;

  localparam int WIDTH  = 2;
  localparam int STABLE = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  input_debouncer_if #(.WIDTH(WIDTH)) bus ();

  input_debouncer #(
    .WIDTH         (WIDTH),
    .STABLE_CYCLES (STABLE),
    .INVERT        (1'b1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [WIDTH-1:0] m_s1, m_s2, m_db, m_rise, m_fall, m_flags;
  logic             m_irq;
  bit               m_win [WIDTH][STABLE];

  logic [4*WIDTH:0] obs;
  logic [4*WIDTH:0] exp_m;
  assign obs   = {bus.db_out, bus.rise_pulse, bus.fall_pulse, bus.evt_flags, bus.irq};
  assign exp_m = {m_db, m_rise, m_fall, m_flags, m_irq};

  // Model: the level flips once the last STABLE normalised samples all differ
  // from it; samples reach the decision two clocks after the pin is sampled.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1    = '1;
      m_s2    = '1;
      m_db    = '0;
      m_rise  = '0;
      m_fall  = '0;
      m_flags = '0;
      m_irq   = 1'b0;
      foreach (m_win[c, k]) m_win[c][k] = 1'b0;
    end else begin
      logic [WIDTH-1:0] norm;
      bit               all_diff;
      norm = ~m_s2;
`ifdef DEBOUNCE_EVT_EN
      m_irq   = |m_flags;
      m_flags = (m_flags & ~bus.evt_clear) | m_rise;
`endif
      m_rise = '0;
      m_fall = '0;
      for (int c = 0; c < WIDTH; c++) begin
        for (int k = STABLE - 1; k > 0; k--) m_win[c][k] = m_win[c][k-1];
        m_win[c][0] = norm[c];
        all_diff = 1'b1;
        for (int k = 0; k < STABLE; k++) if (m_win[c][k] == m_db[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_db[c] = norm[c];
          if (norm[c]) m_rise[c] = 1'b1;
          else         m_fall[c] = 1'b1;
        end
      end
      m_s2 = m_s1;
      m_s1 = bus.raw_in;
    end
  end

  task automatic test_reset();
    reset_n       = 1'b0;
    bus.raw_in    = 2'b00;
    bus.evt_clear = 2'b00;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs !== '0) $display("FAIL reset_hold: got %b want %b", obs, 9'd0);
    else n_pass++;
    bus.raw_in = 2'b11;
    reset_n    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== '0) $display("FAIL reset_idle[%0d]: got %b want %b", i, obs, 9'd0);
      else n_pass++;
      n_checks++;
      if (obs !== exp_m) $display("FAIL reset_model[%0d]: got %b want %b", i, obs, exp_m);
      else n_pass++;
    end
  endtask

  task automatic test_clean_press();
    logic [5:0] want;
    bus.raw_in = 2'b10;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      want = {1'b0, (i >= 5), 1'b0, (i == 5), 2'b00};
      n_checks++;
      if ({bus.db_out, bus.rise_pulse, bus.fall_pulse} !== want)
        $display("FAIL clean_press[%0d]: got %b want %b", i,
                 {bus.db_out, bus.rise_pulse, bus.fall_pulse}, want);
      else n_pass++;
      n_checks++;
      if (obs !== exp_m) $display("FAIL clean_model[%0d]: got %b want %b", i, obs, exp_m);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    logic [5:0] want;
    bus.raw_in = 2'b11;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_m) $display("FAIL bounce_release_model[%0d]: got %b want %b", i, obs, exp_m);
      else n_pass++;
    end
    // Low for three edges, high for one, then low steady.
    for (int i = 0; i < 14; i++) begin
      bus.raw_in[0] = (i == 3);
      @(negedge clk);
      want = {1'b0, (i >= 9), 1'b0, (i == 9), 2'b00};
      n_checks++;
      if ({bus.db_out, bus.rise_pulse, bus.fall_pulse} !== want)
        $display("FAIL bounce[%0d]: got %b want %b", i,
                 {bus.db_out, bus.rise_pulse, bus.fall_pulse}, want);
      else n_pass++;
      n_checks++;
      if (obs !== exp_m) $display("FAIL bounce_model[%0d]: got %b want %b", i, obs, exp_m);
      else n_pass++;
    end
  endtask

  task automatic test_release_simul();
    logic [5:0] want;
    bus.raw_in = 2'b00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_m) $display("FAIL both_press_model[%0d]: got %b want %b", i, obs, exp_m);
      else n_pass++;
    end
    bus.raw_in = 2'b11;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      want = {((i >= 5) ? 2'b00 : 2'b11), 2'b00, ((i == 5) ? 2'b11 : 2'b00)};
      n_checks++;
      if ({bus.db_out, bus.rise_pulse, bus.fall_pulse} !== want)
        $display("FAIL release_simul[%0d]: got %b want %b", i,
                 {bus.db_out, bus.rise_pulse, bus.fall_pulse}, want);
      else n_pass++;
      n_checks++;
      if (obs !== exp_m) $display("FAIL release_model[%0d]: got %b want %b", i, obs, exp_m);
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    logic [5:0] want;
    bus.raw_in = 2'b10;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (bus.db_out !== 2'b00) $display("FAIL mid_reset_assert: got %b want %b", bus.db_out, 2'b00);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs !== '0) $display("FAIL mid_reset_hold: got %b want %b", obs, 9'd0);
    else n_pass++;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      want = {1'b0, (i >= 5), 1'b0, (i == 5), 2'b00};
      n_checks++;
      if ({bus.db_out, bus.rise_pulse, bus.fall_pulse} !== want)
        $display("FAIL mid_reset_relatch[%0d]: got %b want %b", i,
                 {bus.db_out, bus.rise_pulse, bus.fall_pulse}, want);
      else n_pass++;
      n_checks++;
      if (obs !== exp_m) $display("FAIL mid_reset_model[%0d]: got %b want %b", i, obs, exp_m);
      else n_pass++;
    end
  endtask

`ifdef DEBOUNCE_EVT_EN
  task automatic test_evt_flags();
    logic [2:0] want;
    bus.evt_clear = 2'b11;
    @(negedge clk);
    bus.evt_clear = 2'b00;
    repeat (2) @(negedge clk);
    // Press channel 1 (channel 0 stays pressed).
    bus.raw_in = 2'b00;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      want = {(i == 5), (i >= 6), (i >= 7)};
      n_checks++;
      if ({bus.rise_pulse[1], bus.evt_flags[1], bus.irq} !== want)
        $display("FAIL evt_set[%0d]: got %b want %b", i,
                 {bus.rise_pulse[1], bus.evt_flags[1], bus.irq}, want);
      else n_pass++;
    end
    bus.evt_clear = 2'b10;
    @(negedge clk);
    bus.evt_clear = 2'b00;
    n_checks++;
    if ({bus.evt_flags, bus.irq} !== 3'b001)
      $display("FAIL evt_clear: got %b want %b", {bus.evt_flags, bus.irq}, 3'b001);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({bus.evt_flags, bus.irq} !== 3'b000)
      $display("FAIL evt_irq_drop: got %b want %b", {bus.evt_flags, bus.irq}, 3'b000);
    else n_pass++;
    // Release channel 1, then press again and clear on the pulse cycle.
    bus.raw_in = 2'b10;
    repeat (8) @(negedge clk);
    bus.raw_in = 2'b00;
    repeat (6) @(negedge clk);
    n_checks++;
    if (bus.rise_pulse !== 2'b10) $display("FAIL evt_repress: got %b want %b", bus.rise_pulse, 2'b10);
    else n_pass++;
    bus.evt_clear = 2'b10;
    @(negedge clk);
    bus.evt_clear = 2'b00;
    n_checks++;
    if (bus.evt_flags !== 2'b10) $display("FAIL evt_set_wins: got %b want %b", bus.evt_flags, 2'b10);
    else n_pass++;
    n_checks++;
    if (obs !== exp_m) $display("FAIL evt_model: got %b want %b", obs, exp_m);
    else n_pass++;
  endtask
`else
  task automatic test_evt_disabled();
    for (int i = 0; i < 10; i++) begin
      bus.evt_clear = 2'($urandom_range(3));
      bus.raw_in    = (i < 5) ? 2'b01 : 2'b11;
      @(negedge clk);
      n_checks++;
      if ({bus.evt_flags, bus.irq} !== 3'b000)
        $display("FAIL evt_disabled[%0d]: got %b want %b", i, {bus.evt_flags, bus.irq}, 3'b000);
      else n_pass++;
    end
    bus.evt_clear = 2'b00;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) bus.raw_in[$urandom_range(1)] ^= 1'b1;
      bus.evt_clear = ($urandom_range(7) == 0) ? 2'($urandom_range(3)) : 2'b00;
      @(negedge clk);
      n_checks++;
      if (obs !== exp_m) $display("FAIL random_model[%0d]: got %b want %b", i, obs, exp_m);
      else n_pass++;
    end
    bus.evt_clear = 2'b00;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_simul();
    test_mid_reset();
`ifdef DEBOUNCE_EVT_EN
    test_evt_flags();
`else
    test_evt_disabled();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
